fact_accel: RTL and testbench

Memory-mapped factorial accelerator on the processor's data-memory bus, downstream of the MIPS core's memory stage. The system address decoder asserts `sel` when the core's M-stage address (`alu_out_M`) falls in the accelerator window. The core writes an operand and a start command with `we_dm_M`/`wd_dm_M`, polls status, and reads the 32-bit result through the `rd_dm` return mux. Computation is iterative, one multiply per cycle, under a small control FSM.

---
 rtl/fact_pkg.sv | 12 +
 rtl/fact_accel_if.sv | 10 +
 rtl/fact_dp.sv | 32 +++
 rtl/fact_accel.sv | 74 +++++++
 tb/tb_fact_accel.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fact_pkg.sv
// fact_pkg: register map, FSM encoding and status bit positions shared by the factorial accelerator
package fact_pkg;
  localparam logic [1:0] FACT_N = 2'd0;
  localparam logic [1:0] FACT_GO = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;
  localparam int unsigned N_MAX_DEF = 12;
  localparam int DONE = 0;
  localparam int ERR = 1;
  localparam int BUSY = 2;
  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;
endpackage

// File: rtl/fact_accel_if.sv
// fact_accel_if: data-memory bus slice between the core's memory stage and the accelerator
interface fact_accel_if;
  logic sel;
  logic [1:0] a;
  logic we;
  logic [31:0] wd;
  logic [31:0] rd;
  modport master(output sel, a, we, wd, input rd);
  modport slave(input sel, a, we, wd, output rd);
endinterface

// File: rtl/fact_dp.sv
// fact_dp: counter, running product, one-multiply-per-cycle step and result register
module fact_dp (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        calc,
  input  logic        err_ld,
  input  logic [3:0]  n,
  output logic        gt1,
  output logic [31:0] result
);
  logic [3:0] cnt;
  logic [31:0] prod;
  assign gt1 = cnt > 4'd1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      prod <= '0;
      result <= '0;
    end else begin
      if (load) begin
        cnt <= n;
        prod <= 32'd1;
      end else if (calc && gt1) begin
        prod <= prod * {28'd0, cnt};
        cnt <= cnt - 4'd1;
      end
      if (err_ld) result <= '0;
      else if (calc && !gt1) result <= prod;
    end
  end
endmodule

// File: rtl/fact_accel.sv
// fact_accel: memory-mapped iterative factorial accelerator with control FSM and register file
module fact_accel import fact_pkg::*; #(
  parameter int unsigned N_MAX = N_MAX_DEF
) (
  input logic clk,
  input logic rst,
  fact_accel_if.slave bus
);
  state_t state, nxt;
  logic [3:0] n;
  logic done, err, busy, load, calc, err_ld, gt1, bad, wr, wr_n, start;
  logic [31:0] result;
  logic [2:0] status;
  logic unused_wd;
  assign unused_wd = ^bus.wd[31:4];
  assign wr = bus.sel && bus.we;
  assign wr_n = wr && bus.a == FACT_N;
  assign start = wr && bus.a == FACT_GO && bus.wd[0];
  assign bad = 32'(n) > N_MAX;
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? LOAD : IDLE) :
          state == LOAD ? (bad ? IDLE : CALC) :
          (gt1 ? CALC : IDLE);
  end
  always_comb begin
    load = state == LOAD && !bad;
    err_ld = state == LOAD && bad;
    calc = state == CALC;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      n <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      if (wr_n) n <= bus.wd[3:0];
      if (state == IDLE && start) begin
        done <= 1'b0;
        err <= 1'b0;
      end else if (err_ld) begin
        done <= 1'b1;
        err <= 1'b1;
      end else if (calc && !gt1) done <= 1'b1;
    end
  end
  fact_dp u_dp (
    .clk(clk),
    .rst(rst),
    .load(load),
    .calc(calc),
    .err_ld(err_ld),
    .n(n),
    .gt1(gt1),
    .result(result)
  );
  always_comb begin
    status = '0;
    status[DONE] = done;
    status[ERR] = err;
    status[BUSY] = busy;
  end
  always_comb begin
    bus.rd = !bus.sel ? '0 :
             bus.a == FACT_N ? {28'd0, n} :
             bus.a == FACT_STATUS ? {29'd0, status} :
             bus.a == FACT_RESULT ? result : '0;
  end
endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: directed register-level stimulus with a queued scoreboard checked on each bus read
module tb_fact_accel;
  import fact_pkg::*;
  typedef struct {
    logic [31:0] exp;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic rd_vld = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  exp_t sb[$];
  fact_accel_if bus();
  fact_accel #(.N_MAX(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #10 clk = ~clk;
  always @(posedge rd_vld) begin
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_read: rd=%0d with no expected value queued", bus.rd);
    end else begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (bus.rd !== e.exp) begin
        n_fail++;
        $display("FAIL %s: rd=%0d (0x%08h) expected %0d (0x%08h)", e.name, bus.rd, bus.rd, e.exp, e.exp);
      end
    end
  end
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1;
    bus.we = 1'b1;
    bus.a = a;
    bus.wd = d;
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    bus.we = 1'b0;
  endtask
  task automatic go();
    wr(FACT_GO, 32'd1);
  endtask
  task automatic chk(input logic s, input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.sel = s;
    bus.we = 1'b0;
    bus.a = a;
    sb.push_back('{exp, name});
    #1 rd_vld = 1'b1;
    #1 rd_vld = 1'b0;
    bus.sel = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b0;
    bus.sel = 1'b0;
    bus.we = 1'b0;
    bus.a = '0;
    bus.wd = '0;
    step(2);
    rst = 1'b1;
    wr(FACT_N, 32'hFFFF_FFF7);
    chk(1, FACT_N, 7, "n_write_masked");
    chk(0, FACT_N, 0, "rd_zero_unselected");
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    chk(1, FACT_N, 0, "rst_n");
    chk(1, FACT_GO, 0, "rst_go");
    chk(1, FACT_STATUS, 0, "rst_status");
    chk(1, FACT_RESULT, 0, "rst_result");
    wr(FACT_N, 5);
    go();
    chk(1, FACT_STATUS, 4, "n5_busy_e0");
    chk(1, FACT_GO, 0, "go_reads_zero");
    step(5);
    chk(1, FACT_STATUS, 4, "n5_busy_e5");
    chk(1, FACT_RESULT, 0, "n5_result_held");
    step(1);
    chk(1, FACT_STATUS, 1, "n5_done_e6");
    chk(1, FACT_RESULT, 120, "n5_result");
    wr(FACT_N, 0);
    go();
    step(1);
    chk(1, FACT_STATUS, 4, "n0_busy_e1");
    step(1);
    chk(1, FACT_STATUS, 1, "n0_done_e2");
    chk(1, FACT_RESULT, 1, "n0_result");
    wr(FACT_N, 1);
    go();
    chk(1, FACT_STATUS, 4, "n1_start_clears_done");
    step(2);
    chk(1, FACT_STATUS, 1, "n1_done_e2");
    chk(1, FACT_RESULT, 1, "n1_result");
    wr(FACT_N, 12);
    go();
    step(12);
    chk(1, FACT_STATUS, 4, "n12_busy_e12");
    step(1);
    chk(1, FACT_STATUS, 1, "n12_done_e13");
    chk(1, FACT_RESULT, 32'h1C8C_FC00, "n12_result");
    wr(FACT_N, 13);
    go();
    step(1);
    chk(1, FACT_STATUS, 3, "n13_err");
    chk(1, FACT_RESULT, 0, "n13_result_zero");
    chk(1, FACT_N, 13, "n13_readback");
    wr(FACT_N, 3);
    go();
    chk(1, FACT_STATUS, 4, "n3_err_cleared");
    step(3);
    chk(1, FACT_STATUS, 4, "n3_busy_e3");
    step(1);
    chk(1, FACT_STATUS, 1, "n3_done_e4");
    chk(1, FACT_RESULT, 6, "n3_result");
    wr(FACT_N, 6);
    go();
    step(1);
    wr(FACT_N, 2);
    go();
    chk(1, FACT_N, 2, "n6_n_updated_busy");
    step(3);
    chk(1, FACT_STATUS, 4, "n6_busy_e6");
    chk(1, FACT_RESULT, 6, "n6_result_held");
    step(1);
    chk(1, FACT_STATUS, 1, "n6_done_e7");
    chk(1, FACT_RESULT, 720, "n6_result");
    chk(1, FACT_N, 2, "n6_n_after");
    wr(FACT_N, 4);
    go();
    wr(FACT_N, 9);
    step(3);
    chk(1, FACT_STATUS, 4, "load_race_busy_e4");
    step(1);
    chk(1, FACT_STATUS, 1, "load_race_done_e5");
    chk(1, FACT_RESULT, 24, "load_race_old_n");
    wr(FACT_N, 10);
    go();
    step(2);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk(1, FACT_STATUS, 0, "midrst_status");
    chk(1, FACT_RESULT, 0, "midrst_result");
    chk(1, FACT_N, 0, "midrst_n");
    wr(FACT_N, 4);
    go();
    step(5);
    chk(1, FACT_STATUS, 1, "after_rst_done_e5");
    chk(1, FACT_RESULT, 24, "after_rst_result");
    step(2);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
